writeback_queue: RTL and testbench
==================================

# writeback_queue

Writeback buffer between the execute/load stages and the register file write port. Accepts destination/result pairs from the ALU and the load unit, holds them in a small in-order FIFO, and drains them one per cycle onto the register file's `RegWrite`/`Rd`/`Write_data` inputs whenever the port is free. It also reports read-after-write hazards on the register file read addresses, so the decode stage can stall until a queued result has been written.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; must be a power of 2, ≥2.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ld_valid`  in  1  load result valid.
- `ld_ready`  out  1  load result accepted this cycle when high with `ld_valid`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  XLEN  load result.
- `alu_valid`  in  1  ALU result valid.
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `rf_ready`  in  1  register file write port free this cycle.
- `RegWrite`  out  1  write enable to register file.
- `Rd`  out  5  write address.
- `Write_data`  out  XLEN  write data.
- `Rs1`, `Rs2`  in  5 each  register file read addresses from decode.
- `hazard1`, `hazard2`  out  1 each  queued write pending to `Rs1`/`Rs2`.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `full`, `empty`  out  1 each  occupancy flags.
- `fwd_data1`, `fwd_data2`  out  XLEN each  present only with `WB_FORWARD_EN`.

## Operation
- Storage: circular FIFO of {rd, data}; write pointer and read pointer wrap modulo `DEPTH`; `count` tracks occupancy.
- Enqueue, at most one per cycle:
  - `ld_ready = !full`.
  - `alu_ready = !full && !ld_valid`, so the load unit has fixed priority.
- A handshake with rd == 0 completes normally, but nothing is stored: `count` and pointers are unchanged.
- Drain:
  - `RegWrite = !empty`, with `Rd`/`Write_data` taken from the head entry.
  - The head pops at the edge where `RegWrite && rf_ready`.
  - When `empty`, `Rd` and `Write_data` are 0.
- Simultaneous enqueue and pop: `count` is unchanged and both pointers advance.
- When full, no enqueue is allowed, even if a pop happens in the same cycle. `ready` is based only on `full`.
- Hazard detection:
  - `hazardN = (RsN != 0) && (some valid entry has rd == RsN)`.
  - Entries are compared combinationally over all valid entries, including the head currently being presented.
- Order: entries are written to the register file strictly in enqueue order, so a later result for the same rd overwrites an earlier one.

## Timing
- Reset, synchronous: pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `RegWrite` = 0, `Rd` = 0, `Write_data` = 0, `hazard1`/`hazard2` = 0.
  - Reset mid-operation discards all queued entries; no write is issued in the cycle after reset.
- Latency: a result accepted at edge N appears on the write port in cycle N+1, if the queue was empty. It is written at the first later edge where `rf_ready` = 1.
- Throughput: one enqueue and one drain per cycle.
- The `ready` outputs are combinational from `full` and `ld_valid`. There is no combinational path from `rf_ready` to the `ready` outputs.
- `hazardN` reflects the queue state after the previous edge. It is combinational from `RsN`.

## Configuration
- `WB_FORWARD_EN` defined:
  - `fwd_dataN` outputs are present, driven with the data of the youngest valid entry whose rd == RsN, and 0 when there is no match.
  - `hazardN` keeps its meaning and now acts as the forward-select qualifier.
- `WB_FORWARD_EN` undefined:
  - The `fwd_data1`/`fwd_data2` ports and comparison mux are not compiled.
  - Decode must stall on `hazardN`.

## Test plan
- Reset, then `ld_valid` with rd=5, data=0xDEADBEEF, `rf_ready`=1 → the next cycle shows `RegWrite`=1, `Rd`=5, `Write_data`=0xDEADBEEF; the cycle after that, `empty`=1.
- `ld_valid` and `alu_valid` in the same cycle (rd 3, rd 4) → `ld_ready`=1 and `alu_ready`=0. The ALU result is accepted next cycle, and the writes occur in order rd 3, then rd 4.
- Hold `rf_ready`=0 and enqueue 4 ALU results (rd 1–4) → `full`=1, `count`=4, `alu_ready`=0. Release `rf_ready` → 4 consecutive writes, rd 1..4; then `empty`=1 and pointers have wrapped. A further enqueue is written correctly.
- With `rf_ready`=0, enqueue rd=7 with 0x11 then rd=7 with 0x22, and set `Rs1`=7, `Rs2`=0 → `hazard1`=1, `hazard2`=0. With forwarding compiled in, `fwd_data1`=0x22. After both drain, `hazard1`=0.
- Enqueue with rd=0 → accepted with `ready`=1, `count` stays 0, no `RegWrite`.
- Fill 3 entries with `rf_ready`=0, then assert `reset` for one cycle → `count`=0, `RegWrite`=0, `hazard1`/`hazard2`=0. No stale write appears after reset deasserts.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback buffer: in-order FIFO feeding the register file write port.
// Define WB_FORWARD_EN to add fwd_data1/fwd_data2 forwarding outputs.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_rd,
    input  logic [XLEN-1:0]           ld_data,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      rf_ready,
    output logic                      RegWrite,
    output logic [4:0]                Rd,
    output logic [XLEN-1:0]           Write_data,
    input  logic [4:0]                Rs1,
    input  logic [4:0]                Rs2,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
`ifdef WB_FORWARD_EN
    ,
    output logic [XLEN-1:0]           fwd_data1,
    output logic [XLEN-1:0]           fwd_data2
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_in_rd;
    logic [XLEN-1:0] w_in_data;
    logic            w_hz1;
    logic            w_hz2;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Load unit has fixed priority; readiness never depends on rf_ready.
    assign ld_ready  = !w_full;
    assign alu_ready = !w_full && !ld_valid;

    assign w_in_rd   = ld_valid ? ld_rd : alu_rd;
    assign w_in_data = ld_valid ? ld_data : alu_data;
    assign w_push    = !w_full && (ld_valid || alu_valid) && (w_in_rd != 5'd0);
    assign w_pop     = !w_empty && rf_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Push and pop slots only coincide when empty or full,
            // where one of the two is blocked.
            if (w_push) begin
                r_rd[r_wptr]    <= w_in_rd;
                r_data[r_wptr]  <= w_in_data;
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign RegWrite   = !w_empty;
    assign Rd         = w_empty ? 5'd0 : r_rd[r_rptr];
    assign Write_data = w_empty ? '0 : r_data[r_rptr];
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

    always_comb begin
        w_hz1 = 1'b0;
        w_hz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_rd[i] == Rs1)) w_hz1 = 1'b1;
            if (r_valid[i] && (r_rd[i] == Rs2)) w_hz2 = 1'b1;
        end
    end

    assign hazard1 = w_hz1 && (Rs1 != 5'd0);
    assign hazard2 = w_hz2 && (Rs2 != 5'd0);

`ifdef WB_FORWARD_EN
    logic [AW-1:0] w_idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_data1 = '0;
        fwd_data2 = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr + AW'(k);
            if (r_valid[w_idx] && (r_rd[w_idx] == Rs1)) fwd_data1 = r_data[w_idx];
            if (r_valid[w_idx] && (r_rd[w_idx] == Rs2)) fwd_data2 = r_data[w_idx];
        end
    end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed + random bench for writeback_queue with a queue scoreboard.
// Expected writes are pushed on modelled accepts and popped on drains.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            rf_ready;
    logic            RegWrite;
    logic [4:0]      Rd;
    logic [XLEN-1:0] Write_data;
    logic [4:0]      Rs1;
    logic [4:0]      Rs2;
    logic            hazard1;
    logic            hazard2;
    logic [2:0]      count;
    logic            full;
    logic            empty;
`ifdef WB_FORWARD_EN
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;
`endif

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .rf_ready   (rf_ready),
        .RegWrite   (RegWrite),
        .Rd         (Rd),
        .Write_data (Write_data),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef WB_FORWARD_EN
        ,
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic v, input logic [4:0] rd,
                      input logic [XLEN-1:0] d);
        ld_valid = v;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd,
                       input logic [XLEN-1:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    // Check all outputs against the model, update it, advance one clock.
    task automatic cycle();
        bit              mfull;
        bit              h1;
        bit              h2;
        logic [XLEN-1:0] f1;
        logic [XLEN-1:0] f2;
        ent_t            e;
        #3;
        mfull = (sb.size() == DEPTH);
        h1 = 1'b0;
        h2 = 1'b0;
        f1 = '0;
        f2 = '0;
        foreach (sb[i]) begin
            if (sb[i].rd == Rs1 && Rs1 != 0) begin h1 = 1'b1; f1 = sb[i].data; end
            if (sb[i].rd == Rs2 && Rs2 != 0) begin h2 = 1'b1; f2 = sb[i].data; end
        end
        chk("ld_ready", ld_ready, !mfull);
        chk("alu_ready", alu_ready, !mfull && !ld_valid);
        chk("count", count, sb.size());
        chk("full", full, mfull);
        chk("empty", empty, sb.size() == 0);
        chk("RegWrite", RegWrite, sb.size() != 0);
        if (sb.size() != 0) begin
            chk("Rd", Rd, sb[0].rd);
            chk("Write_data", Write_data, sb[0].data);
        end else begin
            chk("Rd_idle", Rd, 0);
            chk("Write_data_idle", Write_data, 0);
        end
        chk("hazard1", hazard1, h1);
        chk("hazard2", hazard2, h2);
`ifdef WB_FORWARD_EN
        chk("fwd_data1", fwd_data1, f1);
        chk("fwd_data2", fwd_data2, f2);
`endif
        if (sb.size() != 0 && rf_ready) void'(sb.pop_front());
        if (!mfull) begin
            if (ld_valid && ld_rd != 0) begin
                e.rd = ld_rd; e.data = ld_data; sb.push_back(e);
            end else if (!ld_valid && alu_valid && alu_rd != 0) begin
                e.rd = alu_rd; e.data = alu_data; sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        ld(0, 0, 0);
        alu(0, 0, 0);
        rf_ready = 1'b0;
        Rs1 = 5'd0;
        Rs2 = 5'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state, then single load with immediate drain.
        Rs1 = 5'd5;
        Rs2 = 5'd3;
        cycle();
        rf_ready = 1'b1;
        ld(1, 5, 32'hDEADBEEF);
        cycle();
        ld(0, 0, 0);
        cycle();
        cycle();

        // Load beats ALU; ALU held and accepted next cycle.
        ld(1, 3, 32'hAAAA0003);
        alu(1, 4, 32'hBBBB0004);
        cycle();
        ld(0, 0, 0);
        cycle();
        alu(0, 0, 0);
        repeat (3) cycle();

        // Fill while stalled, hold an extra ALU result while full.
        rf_ready = 1'b0;
        Rs1 = 5'd2;
        Rs2 = 5'd4;
        for (int i = 1; i <= 4; i++) begin
            alu(1, 5'(i), 32'h100 + i);
            cycle();
        end
        alu(1, 9, 32'h999);
        cycle();
        rf_ready = 1'b1;
        cycle();
        alu(0, 0, 0);
        repeat (5) cycle();
        alu(1, 12, 32'hC0FFEE);
        cycle();
        alu(0, 0, 0);
        repeat (2) cycle();

        // Same rd twice: hazard and youngest forward.
        rf_ready = 1'b0;
        Rs1 = 5'd7;
        Rs2 = 5'd0;
        ld(1, 7, 32'h11);
        cycle();
        ld(1, 7, 32'h22);
        cycle();
        ld(0, 0, 0);
        cycle();
        rf_ready = 1'b1;
        repeat (3) cycle();

        // rd = 0 is accepted but never stored.
        ld(1, 0, 32'h55);
        cycle();
        ld(0, 0, 0);
        alu(1, 0, 32'h66);
        cycle();
        alu(0, 0, 0);
        cycle();

        // Reset with queued entries: nothing survives.
        rf_ready = 1'b0;
        Rs1 = 5'd21;
        Rs2 = 5'd22;
        for (int i = 0; i < 3; i++) begin
            alu(1, 5'(20 + i), 32'h2000 + i);
            cycle();
        end
        alu(0, 0, 0);
        do_reset();
        rf_ready = 1'b1;
        repeat (2) cycle();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            ld(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            rf_ready = 1'($urandom_range(0, 2) != 0);
            Rs1 = 5'($urandom_range(0, 7));
            Rs2 = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
